// File: rtl/axi_bram_pkg.sv
// rtl/axi_bram_pkg.sv - shared constants and helpers for the AXI BRAM writer
package axi_bram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Ceiling log2; used to find the byte-offset bits of an AXI word address.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_bram_writer_slot.sv
// rtl/axi_bram_writer_slot.sv - one-entry hold register with valid/ready capture and clear
module axi_bram_writer_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
    output logic             o_ready,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

    assign o_ready = ~r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/axi_bram_writer.sv
// rtl/axi_bram_writer.sv - AXI4-Lite write slave driving BRAM port A
// Optional: define AXI_BRAM_WRITER_SLVERR_EN to reject out-of-range addresses with SLVERR.
module axi_bram_writer
    import axi_bram_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 10
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [AXI_ADDR_WIDTH-1:0]    s_axi_awaddr,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]    s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]  s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    output logic                         bram_porta_clk,
    output logic                         bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
    output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata,
    output logic [BRAM_DATA_WIDTH/8-1:0] bram_porta_we
);

    localparam int ADDR_LSB = clogb2(AXI_DATA_WIDTH / 8);
    localparam int STRB_W   = AXI_DATA_WIDTH / 8;

    logic                                w_aw_full;
    logic                                w_w_full;
    logic [AXI_ADDR_WIDTH-1:0]           w_held_awaddr;
    logic [AXI_DATA_WIDTH+STRB_W-1:0]    w_held_w;
    logic [AXI_DATA_WIDTH-1:0]           w_held_wdata;
    logic [STRB_W-1:0]                   w_held_wstrb;
    logic                                w_commit;
    logic                                w_addr_err;
    logic                                r_b_full;
    logic [1:0]                          r_bresp;

    axi_bram_writer_slot #(.WIDTH(AXI_ADDR_WIDTH)) u_aw_slot (
        .clk     (aclk),
        .rst     (areset),
        .i_valid (s_axi_awvalid),
        .i_data  (s_axi_awaddr),
        .i_clear (w_commit),
        .o_ready (s_axi_awready),
        .o_full  (w_aw_full),
        .o_data  (w_held_awaddr)
    );

    axi_bram_writer_slot #(.WIDTH(AXI_DATA_WIDTH + STRB_W)) u_w_slot (
        .clk     (aclk),
        .rst     (areset),
        .i_valid (s_axi_wvalid),
        .i_data  ({s_axi_wdata, s_axi_wstrb}),
        .i_clear (w_commit),
        .o_ready (s_axi_wready),
        .o_full  (w_w_full),
        .o_data  (w_held_w)
    );

    assign w_held_wdata = w_held_w[AXI_DATA_WIDTH+STRB_W-1:STRB_W];
    assign w_held_wstrb = w_held_w[STRB_W-1:0];

    // A held pair may commit while its predecessor's response is being accepted.
    assign w_commit = w_aw_full & w_w_full & (~r_b_full | s_axi_bready);

`ifdef AXI_BRAM_WRITER_SLVERR_EN
    assign w_addr_err = |(w_held_awaddr >> (ADDR_LSB + BRAM_ADDR_WIDTH));
`else
    assign w_addr_err = 1'b0;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_b_full <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_b_full <= 1'b1;
            r_bresp  <= w_addr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axi_bready) begin
            r_b_full <= 1'b0;
        end
    end

    assign s_axi_bvalid      = r_b_full;
    assign s_axi_bresp       = r_bresp;

    assign bram_porta_clk    = aclk;
    assign bram_porta_rst    = areset;
    assign bram_porta_addr   = w_held_awaddr[ADDR_LSB +: BRAM_ADDR_WIDTH];
    assign bram_porta_wrdata = w_held_wdata;
    assign bram_porta_we     = (w_commit && !w_addr_err) ? w_held_wstrb : '0;

endmodule

// File: doc/axi_bram_writer.md
Name: axi_bram_writer

Overview:
AXI4-Lite write-only slave that turns AXI write transactions into single-cycle writes on a BRAM port A. It is the write-side counterpart to the BRAM read slave. A PS-side master fills lookup tables or waveform memories through it, while the PL reads the same BRAM from port B. The AW and W channels are accepted independently. Each BRAM write is acknowledged with one B response.

Parameters:
AXI_DATA_WIDTH, 32, AXI data width in bits; must equal BRAM_DATA_WIDTH, multiple of 8.
AXI_ADDR_WIDTH, 32, AXI address width in bits.
BRAM_DATA_WIDTH, 32, BRAM word width in bits.
BRAM_ADDR_WIDTH, 10, BRAM word-address width.

Ports:
aclk  in  1  system clock; all logic on rising edge.
areset  in  1  asynchronous, active-high reset.
s_axi_awaddr  in  AXI_ADDR_WIDTH  write address.
s_axi_awvalid  in  1  write address valid.
s_axi_awready  out  1  write address ready.
s_axi_wdata  in  AXI_DATA_WIDTH  write data.
s_axi_wstrb  in  AXI_DATA_WIDTH/8  byte strobes.
s_axi_wvalid  in  1  write data valid.
s_axi_wready  out  1  write data ready.
s_axi_bresp  out  2  write response.
s_axi_bvalid  out  1  write response valid.
s_axi_bready  in  1  write response ready.
bram_porta_clk  out  1  equals aclk.
bram_porta_rst  out  1  equals areset.
bram_porta_addr  out  BRAM_ADDR_WIDTH  BRAM word address.
bram_porta_wrdata  out  BRAM_DATA_WIDTH  BRAM write data.
bram_porta_we  out  BRAM_DATA_WIDTH/8  per-byte write enable.

Behaviour:
- Constants and address slice:
  - ADDR_LSB = clog2(AXI_DATA_WIDTH/8), which is 2 at default widths.
  - bram_porta_addr = held_awaddr[ADDR_LSB+BRAM_ADDR_WIDTH-1:ADDR_LSB].
- State: flags aw_full, w_full, b_full and registers held_awaddr, held_wdata, held_wstrb. All flags reset to 0 asynchronously.
- Ready signals: s_axi_awready = ~aw_full; s_axi_wready = ~w_full.
- Capture: on awvalid&awready, store awaddr and set aw_full. On wvalid&wready, store wdata/wstrb and set w_full. Both may capture in the same cycle.
- Commit condition (combinational): commit = aw_full & w_full & (~b_full | s_axi_bready).
- On commit:
  - bram_porta_we = held_wstrb for exactly that cycle; otherwise 0.
  - bram_porta_wrdata = held_wdata.
  - Next edge: clear aw_full and w_full, set b_full.
- B channel: s_axi_bvalid = b_full; b_full clears on bvalid&bready unless a commit occurs in the same cycle. s_axi_bresp = 2'b00 (OKAY).
- Latency and throughput:
  - AW/W captured in cycle N, BRAM write in cycle N+1, bvalid in cycle N+2.
  - Maximum rate is one write per 2 cycles.
- Back-pressure: while bvalid is stalled, one further AW/W pair may be captured and held. Its BRAM write is issued in the same cycle as the pending B handshake.
- wstrb = 0: the commit still occurs, with we = 0 and an OKAY response.
- Reset mid-operation: held AW/W data is discarded, no BRAM write occurs, bvalid drops to 0, and both readys return to 1.
- Outputs during reset: awready = 1, wready = 1, bvalid = 0, bresp = 0, we = 0.

Optional Feature:
- Macro: AXI_BRAM_WRITER_SLVERR_EN.
- Defined: if any held_awaddr bit at or above ADDR_LSB+BRAM_ADDR_WIDTH is 1, the commit forces bram_porta_we = 0 and bresp = 2'b10 (SLVERR), held with the response until the B handshake.
- Undefined: upper bits are ignored, so the address aliases/wraps, and bresp is always OKAY.

Decomposition:
- Package axi_bram_pkg holds:
  - function clogb2;
  - constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
- Sub-module axi_bram_writer_slot: a generic one-entry hold register (valid/ready in, full flag, data out, clear input). It is instantiated twice, once for AW and once for W.

Test Plan:
1. AW 0x00000010 and W 0xDEADBEEF/strb 0xF in the same cycle -> next cycle addr=4, wrdata=0xDEADBEEF, we=0xF for one cycle; bvalid the following cycle with bresp=0.
2. W 0x12345678 first, AW 0x00000020 three cycles later -> wready low from the capture until commit; single write at addr=8.
3. bready held low 5 cycles while a second pair (0x24 / 0xA5A5A5A5) is offered -> second pair captured with readys low and no we; we=0xF at addr=9 in the same cycle bready rises.
4. AW 0x0C with strb 0x5 and data 0x11223344 -> we=0x5, addr=3.
5. AW captured, areset pulsed before W arrives, then W alone -> no we ever, bvalid stays 0, awready=1.
6. With AXI_BRAM_WRITER_SLVERR_EN: AW 0x00001000 -> we=0, bresp=2'b10. Without the macro -> write at addr=0, bresp=0.
